ahb_vga_char_master: RTL and testbench
======================================

Name: ahb_vga_char_master

Overview:
AHB-Lite initiator that turns a valid/ready byte stream into single-beat write transfers to the VGA console peripheral, one character per transfer. It is the hardware counterpart of the bench driver: it produces HADDR/HTRANS/HWDATA/HWRITE/HSEL/HREADY toward the VGA slave and consumes its HREADYOUT/DLS_ERROR. It overlaps the next address phase with the current data phase when the stream allows. It also adds wait-state timeout protection and sticky error reporting.

Parameters:
VGA_ADDR, 32'h5000_0000, address driven for every character write
TIMEOUT_CYCLES, 256, consecutive HREADYOUT-low cycles in any bus state before abort (min 2)
CNT_W, 16, width of write counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
char_valid  in  1  character available
char_data  in  8  character code
char_ready  out  1  character accepted when valid&ready at posedge
err_clr  in  1  clears sticky error flags
HADDR  out  32  address-phase address
HTRANS  out  2  00 IDLE, 10 NONSEQ only
HWDATA  out  32  {24'b0, char}
HWRITE  out  1  1 during NONSEQ, else 0
HSEL  out  1  VGA slave select, high with NONSEQ only
HREADY  out  1  combinational copy of HREADYOUT (single-slave system)
HREADYOUT  in  1  slave ready
HRDATA  in  32  unused, ignored
DLS_ERROR  in  1  peripheral error indication
busy  out  1  state != IDLE
timeout_err  out  1  sticky wait-state timeout
dls_err  out  1  sticky DLS_ERROR capture
wr_count  out  CNT_W  completed writes, wraps

Behaviour:
- Reset (async, immediate): HTRANS=00, HADDR=0, HWDATA=0, HWRITE=0, HSEL=0, wr_count=0, timeout_err=0, dls_err=0, state IDLE. Any pending character is dropped.
- All bus outputs are registered except HREADY. char_ready is combinational from state: 1 in IDLE and DATA, 0 otherwise.
- Registers: cur (8b pending char), HWDATA reg (separate, holds in-flight data).
- States:
  - IDLE: accept on char_valid. Then cur<=char_data; drive HTRANS=10, HADDR=VGA_ADDR, HWRITE=1, HSEL=1; go to ADDR.
  - ADDR: on HREADYOUT=1, HWDATA<={24'b0,cur}, HTRANS=00, HWRITE=0, HSEL=0; go to DATA. Otherwise hold all outputs.
  - DATA: the outcome depends on HREADYOUT and char_valid.
    - HREADYOUT=1, char_valid=0: wr_count++; go to IDLE.
    - HREADYOUT=1, char_valid=1: wr_count++; accept; drive NONSEQ as in IDLE; go to ADDR.
    - HREADYOUT=0, char_valid=1: accept into cur; drive NONSEQ with HWDATA unchanged; go to DATA_ADDR.
    - Otherwise: hold.
  - DATA_ADDR (overlapped phases): on HREADYOUT=1, wr_count++, HWDATA<={24'b0,cur}, HTRANS=00, HSEL=0, HWRITE=0; go to DATA. Otherwise hold.
- Latency: accepted at edge N → NONSEQ visible after N → data phase after N+1 (zero wait) → wr_count increments at N+2 edge.
- Timeout: wait counter increments each cycle in ADDR/DATA/DATA_ADDR with HREADYOUT=0; it clears on HREADYOUT=1 or in IDLE. When the count reaches TIMEOUT_CYCLES:
  - timeout_err<=1
  - bus outputs driven to reset values, excluding wr_count
  - cur dropped, go to IDLE
  - wr_count not incremented
- Stickies: dls_err set by DLS_ERROR=1 (any state); timeout_err set as above. err_clr clears both. Set and clear in the same cycle: set wins.
- wr_count wraps 2^CNT_W-1 → 0.

Decomposition:
- Package ahb_vga_pkg:
  - HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10
  - state enum {IDLE, ADDR, DATA, DATA_ADDR}
  - VGA_ADDR default constant
- Sub-module ahb_wait_timer: parameterised saturating counter with en/clr inputs and an expire output.

Test Plan:
1. Reset: hold rst_n=0 5 cycles, then release → all bus outputs 0, char_ready=1, busy=0, wr_count=0. Assert rst_n mid-cycle → outputs clear without a clock edge.
2. Single write, zero wait: char 0x41 valid one cycle at edge N with HREADYOUT=1.
   - After N: HTRANS=10, HADDR=0x5000_0000, HWRITE=1, HSEL=1.
   - After N+1: HTRANS=00, HWDATA=0x0000_0041.
   - After N+2: wr_count=1, busy=0.
3. Overlap with waits: stream 0x48, 0x49; hold HREADYOUT=0 for 3 cycles during the first data phase.
   - DATA_ADDR entered: HWDATA stays 0x48 while NONSEQ is driven; char_ready=0.
   - After release: HWDATA=0x49.
   - Final wr_count=2.
4. Timeout: TIMEOUT_CYCLES=8, HREADYOUT stuck 0 from the address phase → at the 8th cycle timeout_err=1, HTRANS=00, HSEL=0, busy=0, wr_count unchanged. Pulse err_clr → timeout_err=0.
5. DLS_ERROR one-cycle pulse → dls_err=1 held. DLS_ERROR and err_clr in the same cycle → dls_err stays 1. err_clr alone → 0.
6. 65536 writes with CNT_W=16 → wr_count wraps to 0, no bus glitches.

Source files
------------

// File: rtl/ahb_vga_pkg.sv
// Shared constants, state encoding and data-lane helper for the VGA character master.
package ahb_vga_pkg;

    localparam logic [1:0]  HTRANS_IDLE      = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ    = 2'b10;
    localparam logic [31:0] VGA_ADDR_DEFAULT = 32'h5000_0000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ADDR      = 2'b01,
        ST_DATA      = 2'b10,
        ST_DATA_ADDR = 2'b11
    } state_t;

    // Place a character on the low byte lane of the 32-bit write bus.
    function automatic logic [31:0] char_word(input logic [7:0] c);
        return {24'h00_0000, c};
    endfunction

endpackage

// File: rtl/ahb_vga_char_master_if.sv
// AHB-Lite signal bundle between the character master and the VGA console slave.
interface ahb_vga_char_master_if;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HSEL;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        DLS_ERROR;

    modport master (
        output HADDR, HTRANS, HWDATA, HWRITE, HSEL, HREADY,
        input  HREADYOUT, HRDATA, DLS_ERROR
    );

    modport slave (
        input  HADDR, HTRANS, HWDATA, HWRITE, HSEL, HREADY,
        output HREADYOUT, HRDATA, DLS_ERROR
    );

endinterface

// File: rtl/ahb_wait_timer.sv
// Saturating wait-state counter; expire fires on the cycle whose edge would reach LIMIT.
module ahb_wait_timer #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] r_cnt;

    // Count stalled cycles, clear on progress, hold at LIMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != W'(LIMIT))) begin
            r_cnt <= r_cnt + W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign expire = en && !clr && (r_cnt == W'(LIMIT - 1));

endmodule

// File: rtl/ahb_vga_char_master.sv
// AHB-Lite initiator writing one streamed character per single-beat transfer to the
// VGA console, overlapping the next address phase with a stalled data phase.
module ahb_vga_char_master
    import ahb_vga_pkg::*;
#(
    parameter logic [31:0] VGA_ADDR       = VGA_ADDR_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter int          CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 char_valid,
    input  logic [7:0]           char_data,
    output logic                 char_ready,
    input  logic                 err_clr,
    ahb_vga_char_master_if.master bus,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 dls_err,
    output logic [CNT_W-1:0]     wr_count
);

    state_t           r_state;
    logic [7:0]       r_cur;
    logic [31:0]      r_haddr;
    logic [31:0]      r_hwdata;
    logic [1:0]       r_htrans;
    logic             r_hwrite;
    logic             r_hsel;
    logic [CNT_W-1:0] r_wr_count;
    logic             r_timeout_err;
    logic             r_dls_err;

    logic w_expire;
    logic w_wait_en;
    logic w_wait_clr;
    logic w_unused;

    assign w_wait_en  = (r_state != ST_IDLE) && !bus.HREADYOUT;
    assign w_wait_clr = (r_state == ST_IDLE) || bus.HREADYOUT;
    assign w_unused   = ^bus.HRDATA;

    ahb_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (w_wait_en),
        .clr    (w_wait_clr),
        .expire (w_expire)
    );

    // Transfer sequencer, registered bus outputs, write counter and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cur         <= 8'h00;
            r_haddr       <= 32'h0000_0000;
            r_hwdata      <= 32'h0000_0000;
            r_htrans      <= HTRANS_IDLE;
            r_hwrite      <= 1'b0;
            r_hsel        <= 1'b0;
            r_wr_count    <= '0;
            r_timeout_err <= 1'b0;
            r_dls_err     <= 1'b0;
        end else begin
            // Sticky flags: a new set event beats a simultaneous clear.
            if (bus.DLS_ERROR) begin
                r_dls_err <= 1'b1;
            end else if (err_clr) begin
                r_dls_err <= 1'b0;
            end else begin
                r_dls_err <= r_dls_err;
            end
            if (w_expire) begin
                r_timeout_err <= 1'b1;
            end else if (err_clr) begin
                r_timeout_err <= 1'b0;
            end else begin
                r_timeout_err <= r_timeout_err;
            end

            if (w_expire) begin
                // Abort: abandon whatever is in flight, counter untouched.
                r_state  <= ST_IDLE;
                r_cur    <= 8'h00;
                r_haddr  <= 32'h0000_0000;
                r_hwdata <= 32'h0000_0000;
                r_htrans <= HTRANS_IDLE;
                r_hwrite <= 1'b0;
                r_hsel   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (char_valid) begin
                            r_cur    <= char_data;
                            r_haddr  <= VGA_ADDR;
                            r_htrans <= HTRANS_NONSEQ;
                            r_hwrite <= 1'b1;
                            r_hsel   <= 1'b1;
                            r_state  <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        if (bus.HREADYOUT) begin
                            r_hwdata <= char_word(r_cur);
                            r_htrans <= HTRANS_IDLE;
                            r_hwrite <= 1'b0;
                            r_hsel   <= 1'b0;
                            r_state  <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (bus.HREADYOUT) begin
                            r_wr_count <= r_wr_count + CNT_W'(1);
                            if (char_valid) begin
                                r_cur    <= char_data;
                                r_haddr  <= VGA_ADDR;
                                r_htrans <= HTRANS_NONSEQ;
                                r_hwrite <= 1'b1;
                                r_hsel   <= 1'b1;
                                r_state  <= ST_ADDR;
                            end else begin
                                r_state  <= ST_IDLE;
                            end
                        end else if (char_valid) begin
                            // Stalled data phase: issue the next address phase alongside it.
                            r_cur    <= char_data;
                            r_haddr  <= VGA_ADDR;
                            r_htrans <= HTRANS_NONSEQ;
                            r_hwrite <= 1'b1;
                            r_hsel   <= 1'b1;
                            r_state  <= ST_DATA_ADDR;
                        end
                    end
                    ST_DATA_ADDR: begin
                        if (bus.HREADYOUT) begin
                            r_wr_count <= r_wr_count + CNT_W'(1);
                            r_hwdata   <= char_word(r_cur);
                            r_htrans   <= HTRANS_IDLE;
                            r_hwrite   <= 1'b0;
                            r_hsel     <= 1'b0;
                            r_state    <= ST_DATA;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.HADDR   = r_haddr;
    assign bus.HTRANS  = r_htrans;
    assign bus.HWDATA  = r_hwdata;
    assign bus.HWRITE  = r_hwrite;
    assign bus.HSEL    = r_hsel;
    assign bus.HREADY  = bus.HREADYOUT;

    assign char_ready  = (r_state == ST_IDLE) || (r_state == ST_DATA);
    assign busy        = (r_state != ST_IDLE);
    assign timeout_err = r_timeout_err;
    assign dls_err     = r_dls_err;
    assign wr_count    = r_wr_count;

endmodule

// File: tb/tb_ahb_vga_char_master.sv
// Bench for ahb_vga_char_master: directed steps plus random traffic, checked every
// cycle against a two-slot (address slot / data slot) pipeline model of the master.
module tb_ahb_vga_char_master;

    localparam logic [31:0] TB_VGA = 32'h5000_0000;
    localparam int          TB_TO  = 8;
    localparam int          TB_CW  = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             char_valid = 1'b0;
    logic [7:0]       char_data = 8'h00;
    logic             char_ready;
    logic             err_clr = 1'b0;
    logic             hreadyout = 1'b1;
    logic             dls = 1'b0;
    logic             busy;
    logic             timeout_err;
    logic             dls_err;
    logic [TB_CW-1:0] wr_count;

    ahb_vga_char_master_if bus ();

    assign bus.HREADYOUT = hreadyout;
    assign bus.HRDATA    = 32'hDEAD_BEEF;
    assign bus.DLS_ERROR = dls;

    ahb_vga_char_master #(
        .VGA_ADDR       (TB_VGA),
        .TIMEOUT_CYCLES (TB_TO),
        .CNT_W          (TB_CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .char_valid  (char_valid),
        .char_data   (char_data),
        .char_ready  (char_ready),
        .err_clr     (err_clr),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err),
        .dls_err     (dls_err),
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: an outstanding address phase slot and an outstanding data phase slot.
    bit          m_addr_pend;
    logic [7:0]  m_addr_char;
    bit          m_data_pend;
    int          m_wait;
    int          m_cnt;
    logic [31:0] m_haddr;
    logic [31:0] m_hwdata;
    bit          m_to;
    bit          m_dls;
    bit          m_accept;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr_pend = 0; m_addr_char = 8'h00; m_data_pend = 0; m_wait = 0;
        m_cnt = 0; m_haddr = 32'h0; m_hwdata = 32'h0; m_to = 0; m_dls = 0; m_accept = 0;
    endtask

    // Advance the model by one clock edge using the inputs presented before that edge.
    task automatic model_step();
        bit busy_pre;
        bit expire;
        m_accept = char_valid && !m_addr_pend;
        busy_pre = m_addr_pend || m_data_pend;
        expire   = 0;
        if (busy_pre && !hreadyout) begin
            m_wait++;
            if (m_wait == TB_TO) expire = 1;
        end else begin
            m_wait = 0;
        end
        if (expire) begin
            m_addr_pend = 0; m_data_pend = 0; m_wait = 0;
            m_haddr = 32'h0; m_hwdata = 32'h0;
        end else begin
            if (m_data_pend && hreadyout) begin
                m_data_pend = 0;
                m_cnt++;
            end
            if (m_addr_pend && hreadyout) begin
                m_data_pend = 1;
                m_hwdata    = {24'h0, m_addr_char};
                m_addr_pend = 0;
            end
            if (m_accept) begin
                m_addr_pend = 1;
                m_addr_char = char_data;
                m_haddr     = TB_VGA;
            end
        end
        if (dls) m_dls = 1; else if (err_clr) m_dls = 0;
        if (expire) m_to = 1; else if (err_clr) m_to = 0;
    endtask

    task automatic compare_all();
        logic [TB_CW-1:0] exp_cnt;
        exp_cnt = TB_CW'(m_cnt);
        check("HTRANS",      32'(bus.HTRANS), m_addr_pend ? 32'h2 : 32'h0);
        check("HSEL",        32'(bus.HSEL),   32'(m_addr_pend));
        check("HWRITE",      32'(bus.HWRITE), 32'(m_addr_pend));
        check("HADDR",       bus.HADDR,       m_haddr);
        check("HWDATA",      bus.HWDATA,      m_hwdata);
        check("HREADY",      32'(bus.HREADY), 32'(hreadyout));
        check("char_ready",  32'(char_ready), 32'(!m_addr_pend));
        check("busy",        32'(busy),       32'(m_addr_pend || m_data_pend));
        check("timeout_err", 32'(timeout_err), 32'(m_to));
        check("dls_err",     32'(dls_err),    32'(m_dls));
        check("wr_count",    32'(wr_count),   32'(exp_cnt));
    endtask

    // One clock edge: inputs already driven, sample #1 after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        compare_all();
    endtask

    initial begin
        int k;
        model_reset();

        // 1. Reset held for 5 cycles, then released.
        repeat (5) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
        #1;
        compare_all();
        check("rst_char_ready", 32'(char_ready), 32'h1);

        // 2. Single write, zero wait states.
        char_valid = 1'b1; char_data = 8'h41; hreadyout = 1'b1;
        cycle();
        check("t2_htrans", 32'(bus.HTRANS), 32'h2);
        check("t2_haddr",  bus.HADDR,       32'h5000_0000);
        check("t2_hwrite", 32'(bus.HWRITE), 32'h1);
        check("t2_hsel",   32'(bus.HSEL),   32'h1);
        char_valid = 1'b0;
        cycle();
        check("t2_htrans_d", 32'(bus.HTRANS), 32'h0);
        check("t2_hwdata",   bus.HWDATA,      32'h0000_0041);
        cycle();
        check("t2_count", 32'(wr_count), 32'h1);
        check("t2_busy",  32'(busy),     32'h0);

        // 3. Overlapped phases with three wait states in the first data phase.
        char_valid = 1'b1; char_data = 8'h48; hreadyout = 1'b1;
        cycle();
        char_data = 8'h49;
        cycle();
        check("t3_hwdata_48", bus.HWDATA, 32'h0000_0048);
        hreadyout = 1'b0;
        cycle();
        check("t3_ovl_hwdata", bus.HWDATA,      32'h0000_0048);
        check("t3_ovl_htrans", 32'(bus.HTRANS), 32'h2);
        check("t3_ovl_ready",  32'(char_ready), 32'h0);
        char_valid = 1'b0;
        cycle();
        cycle();
        hreadyout = 1'b1;
        cycle();
        check("t3_hwdata_49", bus.HWDATA, 32'h0000_0049);
        cycle();
        check("t3_count", 32'(wr_count), 32'h3);

        // 4. Wait-state timeout from the address phase.
        char_valid = 1'b1; char_data = 8'h55; hreadyout = 1'b1;
        cycle();
        char_valid = 1'b0; hreadyout = 1'b0;
        for (int i = 1; i < TB_TO; i++) begin
            cycle();
            check("t4_pre_to", 32'(timeout_err), 32'h0);
        end
        cycle();
        check("t4_to",     32'(timeout_err), 32'h1);
        check("t4_htrans", 32'(bus.HTRANS),  32'h0);
        check("t4_hsel",   32'(bus.HSEL),    32'h0);
        check("t4_busy",   32'(busy),        32'h0);
        check("t4_count",  32'(wr_count),    32'h3);
        hreadyout = 1'b1; err_clr = 1'b1;
        cycle();
        check("t4_clr", 32'(timeout_err), 32'h0);
        err_clr = 1'b0;

        // 5. Sticky DLS_ERROR capture and clear priority.
        dls = 1'b1;
        cycle();
        dls = 1'b0;
        cycle();
        check("t5_held", 32'(dls_err), 32'h1);
        dls = 1'b1; err_clr = 1'b1;
        cycle();
        check("t5_setwins", 32'(dls_err), 32'h1);
        dls = 1'b0;
        cycle();
        check("t5_clr", 32'(dls_err), 32'h0);
        err_clr = 1'b0;

        // Random traffic: stream holds data until accepted, random stalls and error pulses.
        for (int i = 0; i < 800; i++) begin
            if (!char_valid || m_accept) begin
                char_valid = ($urandom_range(0, 99) < 60);
                char_data  = 8'($urandom);
            end
            hreadyout = ($urandom_range(0, 99) < 75);
            if ((i % 200) > 190) hreadyout = 1'b0;
            dls     = ($urandom_range(0, 99) < 3);
            err_clr = ($urandom_range(0, 99) < 4);
            cycle();
        end
        dls = 1'b0; err_clr = 1'b0; char_valid = 1'b0; hreadyout = 1'b1;
        cycle();
        cycle();

        // Mid-cycle asynchronous reset with a transfer in flight.
        char_valid = 1'b1; char_data = 8'h7E;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        char_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        compare_all();

        // 6. Continuous stream until the write counter wraps.
        k = 0;
        hreadyout = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (!char_valid || m_accept) begin
                char_valid = 1'b1;
                char_data  = 8'(k);
                k++;
            end
            cycle();
            if (m_cnt == (1 << TB_CW)) check("t6_wrap", 32'(wr_count), 32'h0);
        end
        check("t6_total", 32'(m_cnt > (1 << TB_CW)), 32'(wr_count < 8'd200));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
